// File: rtl/kbd_addr_sequencer.sv
// kbd_addr_sequencer
// Turns keyboard pulses (D stop, E start, B backward, F forward, R restart) into a
// play/direction mode. While playing, each sample tick issues one flash read
// request/acknowledge transaction at the current address. The address then steps
// by STEP, forward or backward, within [START_ADDR, END_ADDR].
//
// Optional feature macro: KBD_SEQ_LOOP_EN
//   defined   - the address wraps around at the bounds.
//   undefined - playback stops at the bound: the address clamps and the mode goes idle.
//
// Ports:
//   clk, rst_n       - clock (rising edge) and asynchronous active-low reset
//   key_[d,e,b,f,r]_i - one-cycle key pulses, priority R > D > E > F > B
//   sample_tick_i    - one-cycle sample-rate strobe
//   rd_ack_i         - flash read done; ignored while no request is pending
//   rd_req_o         - read request, held high until rd_ack_i
//   addr_o           - read address, stable while rd_req_o is high
//   playing_o        - high in the FW or BW mode
//   dir_bw_o         - high when the direction is backward
//   tick_overrun_o   - sticky flag for a tick seen while a request was pending; key R clears it
module kbd_addr_sequencer #(
    parameter int unsigned       ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(20'h7FFFF),
    parameter int unsigned       STEP       = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_d_i,
    input  logic              key_e_i,
    input  logic              key_b_i,
    input  logic              key_f_i,
    input  logic              key_r_i,
    input  logic              sample_tick_i,
    input  logic              rd_ack_i,
    output logic              rd_req_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              playing_o,
    output logic              dir_bw_o,
    output logic              tick_overrun_o
);

    // Bound arithmetic runs one bit wider so that addr + STEP cannot overflow.
    localparam logic [ADDR_W:0] StepX  = (ADDR_W + 1)'(STEP);
    localparam logic [ADDR_W:0] StartX = {1'b0, START_ADDR};
    localparam logic [ADDR_W:0] EndX   = {1'b0, END_ADDR};

    typedef enum logic [1:0] {StIdleFw, StIdleBw, StFw, StBw} mode_e;

    mode_e             mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic              pend_q, pend_d;   // restart latched while a request is outstanding
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              ovr_q, ovr_d;

    logic [ADDR_W:0]   fwd_sum;
    logic              fwd_over;
    logic              bw_under;
    logic [ADDR_W-1:0] bw_next;
    logic [ADDR_W-1:0] restart_tgt;
    logic              ack_evt;

    assign playing_o      = (mode_q == StFw) || (mode_q == StBw);
    assign dir_bw_o       = (mode_q == StIdleBw) || (mode_q == StBw);
    assign rd_req_o       = req_q;
    assign addr_o         = addr_q;
    assign tick_overrun_o = ovr_q;

    assign fwd_sum     = {1'b0, addr_q} + StepX;
    assign fwd_over    = fwd_sum > EndX;
    assign bw_under    = {1'b0, addr_q} < (StartX + StepX);
    assign bw_next     = addr_q - StepX[ADDR_W-1:0];
    assign restart_tgt = dir_bw_o ? END_ADDR : START_ADDR;
    assign ack_evt     = req_q & rd_ack_i;

    always_comb begin
        mode_d = mode_q;
        addr_d = addr_q;
        req_d  = req_q;
        pend_d = pend_q;
        tgt_d  = tgt_q;

        // Key decode: only the highest-priority key acts. Key R leaves the mode alone.
        if (!key_r_i) begin
            if (key_d_i) begin
                case (mode_q)
                    StFw:    mode_d = StIdleFw;
                    StBw:    mode_d = StIdleBw;
                    default: mode_d = mode_q;
                endcase
            end else if (key_e_i) begin
                case (mode_q)
                    StIdleFw: mode_d = StFw;
                    StIdleBw: mode_d = StBw;
                    default:  mode_d = mode_q;
                endcase
            end else if (key_f_i) begin
                case (mode_q)
                    StIdleBw: mode_d = StIdleFw;
                    StBw:     mode_d = StFw;
                    default:  mode_d = mode_q;
                endcase
            end else if (key_b_i) begin
                case (mode_q)
                    StIdleFw: mode_d = StIdleBw;
                    StFw:     mode_d = StBw;
                    default:  mode_d = mode_q;
                endcase
            end
        end

        if (ack_evt) begin
            req_d  = 1'b0;
            pend_d = 1'b0;
            if (key_r_i) begin
                addr_d = restart_tgt;
            end else if (pend_q) begin
                addr_d = tgt_q;
            end else if (!dir_bw_o) begin
                if (fwd_over) begin
`ifdef KBD_SEQ_LOOP_EN
                    addr_d = START_ADDR;
`else
                    addr_d = END_ADDR;
                    mode_d = StIdleFw;
`endif
                end else begin
                    addr_d = fwd_sum[ADDR_W-1:0];
                end
            end else begin
                if (bw_under) begin
`ifdef KBD_SEQ_LOOP_EN
                    addr_d = END_ADDR;
`else
                    addr_d = START_ADDR;
                    mode_d = StIdleBw;
`endif
                end else begin
                    addr_d = bw_next;
                end
            end
        end else if (key_r_i) begin
            // Keep addr frozen under a pending request; apply the restart on the ack.
            if (req_q) begin
                pend_d = 1'b1;
                tgt_d  = restart_tgt;
            end else begin
                addr_d = restart_tgt;
            end
        end

        // A tick in the ack cycle is dropped: req_q is still high there.
        if (sample_tick_i && !req_q && playing_o) begin
            req_d = 1'b1;
        end

        ovr_d = (ovr_q & ~key_r_i) | (sample_tick_i & req_q & ~rd_ack_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= StIdleFw;
            addr_q <= START_ADDR;
            req_q  <= 1'b0;
            pend_q <= 1'b0;
            tgt_q  <= START_ADDR;
            ovr_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            addr_q <= addr_d;
            req_q  <= req_d;
            pend_q <= pend_d;
            tgt_q  <= tgt_d;
            ovr_q  <= ovr_d;
        end
    end

endmodule

// File: tb/tb_kbd_addr_sequencer.sv
// Bench for kbd_addr_sequencer: directed vector table on a small 0..7 instance, plus
// randomized traffic on two instances checked against a behavioural model.
module tb_kbd_addr_sequencer;

    localparam int unsigned AW = 23;
    localparam int S1 = 0;
    localparam int E1 = 7;
    localparam int P1 = 1;
    localparam int S2 = 3;
    localparam int E2 = 17;
    localparam int P2 = 3;

    localparam bit [4:0] K0 = 5'b00000;
    localparam bit [4:0] KR = 5'b10000;
    localparam bit [4:0] KD = 5'b01000;
    localparam bit [4:0] KE = 5'b00100;
    localparam bit [4:0] KF = 5'b00010;
    localparam bit [4:0] KB = 5'b00001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_d, key_e, key_b, key_f, key_r, tick, ack1, ack2;
    logic          req1, ply1, bw1, ovr1, req2, ply2, bw2, ovr2;
    logic [AW-1:0] addr1, addr2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kbd_addr_sequencer #(
        .ADDR_W(AW), .START_ADDR(AW'(S1)), .END_ADDR(AW'(E1)), .STEP(P1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .key_d_i(key_d), .key_e_i(key_e), .key_b_i(key_b),
        .key_f_i(key_f), .key_r_i(key_r), .sample_tick_i(tick), .rd_ack_i(ack1),
        .rd_req_o(req1), .addr_o(addr1), .playing_o(ply1), .dir_bw_o(bw1),
        .tick_overrun_o(ovr1)
    );

    kbd_addr_sequencer #(
        .ADDR_W(AW), .START_ADDR(AW'(S2)), .END_ADDR(AW'(E2)), .STEP(P2)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .key_d_i(key_d), .key_e_i(key_e), .key_b_i(key_b),
        .key_f_i(key_f), .key_r_i(key_r), .sample_tick_i(tick), .rd_ack_i(ack2),
        .rd_req_o(req2), .addr_o(addr2), .playing_o(ply2), .dir_bw_o(bw2),
        .tick_overrun_o(ovr2)
    );

    typedef struct {
        string    nm;
        bit [4:0] k;     // {R, D, E, F, B}
        bit       tk;
        bit       ak;
        bit       xreq;
        int       xaddr;
        bit       xply;
        bit       xbw;
        bit       xovr;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state: playing/backward flags, address, request and restart bookkeeping.
    typedef struct {
        bit ply;
        bit bw;
        int addr;
        bit req;
        bit pend;
        int tgt;
        bit ovr;
    } mst_t;

    function automatic void add(string nm, bit [4:0] k, bit tk, bit ak,
                                bit xr, int xa, bit xp, bit xb, bit xo);
        vec_t v;
        v.nm = nm; v.k = k; v.tk = tk; v.ak = ak;
        v.xreq = xr; v.xaddr = xa; v.xply = xp; v.xbw = xb; v.xovr = xo;
        vecs.push_back(v);
    endfunction

    function automatic logic [31:0] pack(bit r, int a, bit p, bit b, bit o);
        return {5'd0, r, p, b, o, 23'(a)};
    endfunction

    function automatic mst_t mreset(int st);
        mst_t s;
        s.ply = 0; s.bw = 0; s.addr = st; s.req = 0; s.pend = 0; s.tgt = st; s.ovr = 0;
        return s;
    endfunction

    function automatic mst_t mstep(mst_t s, int st, int en, int stp,
                                   bit [4:0] k, bit tk, bit ak);
        mst_t n;
        bit   done;
        int   tgt;
        n    = s;
        done = ak && s.req;
        tgt  = s.bw ? en : st;
        if (k[4]) begin
        end else if (k[3]) n.ply = 0;
        else if (k[2]) n.ply = 1;
        else if (k[1]) n.bw = 0;
        else if (k[0]) n.bw = 1;

        if (done) begin
            n.req  = 0;
            n.pend = 0;
            if (k[4]) n.addr = tgt;
            else if (s.pend) n.addr = s.tgt;
            else if (!s.bw) begin
                if (s.addr + stp <= en) n.addr = s.addr + stp;
                else begin
`ifdef KBD_SEQ_LOOP_EN
                    n.addr = st;
`else
                    n.addr = en; n.ply = 0; n.bw = 0;
`endif
                end
            end else begin
                if (s.addr - stp >= st) n.addr = s.addr - stp;
                else begin
`ifdef KBD_SEQ_LOOP_EN
                    n.addr = en;
`else
                    n.addr = st; n.ply = 0; n.bw = 1;
`endif
                end
            end
        end else if (k[4]) begin
            if (s.req) begin
                n.pend = 1;
                n.tgt  = tgt;
            end else begin
                n.addr = tgt;
            end
        end
        if (tk && !s.req && s.ply) n.req = 1;
        n.ovr = (s.ovr && !k[4]) || (tk && s.req && !ak);
        return n;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {req,ply,bw,ovr,addr}=0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(bit [4:0] k, bit tk, bit a1, bit a2);
        {key_r, key_d, key_e, key_f, key_b} = k;
        tick = tk;
        ack1 = a1;
        ack2 = a2;
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dut1_vec();
        return {5'd0, req1, ply1, bw1, ovr1, addr1};
    endfunction

    function automatic logic [31:0] dut2_vec();
        return {5'd0, req2, ply2, bw2, ovr2, addr2};
    endfunction

    initial begin
        int   a_bw;
        mst_t m1, m2;

        // Test 1: start and three fetches 0, 1, 2.
        add("start", KE, 0, 0, 0, 0, 1, 0, 0);
        for (int a = 0; a < 3; a++) begin
            add("fetch_tick", K0, 1, 0, 1, a, 1, 0, 0);
            add("fetch_wait", K0, 0, 0, 1, a, 1, 0, 0);
            add("fetch_ack", K0, 0, 1, 0, a + 1, 1, 0, 0);
        end
        // Test 2: run up to the top bound.
        for (int a = 3; a < 7; a++) begin
            add("run_tick", K0, 1, 0, 1, a, 1, 0, 0);
            add("run_ack", K0, 0, 1, 0, a + 1, 1, 0, 0);
        end
        add("top_tick", K0, 1, 0, 1, 7, 1, 0, 0);
`ifdef KBD_SEQ_LOOP_EN
        add("wrap_fw", K0, 0, 1, 0, 0, 1, 0, 0);
        add("key_b", KB, 0, 0, 0, 0, 1, 1, 0);
        add("bw_tick", K0, 1, 0, 1, 0, 1, 1, 0);
        add("wrap_bw", K0, 0, 1, 0, 7, 1, 1, 0);
        a_bw = 7;
`else
        add("stop_fw", K0, 0, 1, 0, 7, 0, 0, 0);
        add("key_b_idle", KB, 0, 0, 0, 7, 0, 1, 0);
        add("key_e_bw", KE, 0, 0, 0, 7, 1, 1, 0);
        add("bw_tick", K0, 1, 0, 1, 7, 1, 1, 0);
        add("bw_ack", K0, 0, 1, 0, 6, 1, 1, 0);
        a_bw = 6;
`endif
        // Test 3: long ack hold with two extra ticks, then restart clears overrun.
        add("hold_tick", K0, 1, 0, 1, a_bw, 1, 1, 0);
        for (int i = 0; i < 10; i++)
            add("hold", K0, (i == 2 || i == 6), 0, 1, a_bw, 1, 1, (i >= 2));
        add("ovr_clr", KR, 0, 0, 1, a_bw, 1, 1, 0);
        add("bw_restart_ack", K0, 0, 1, 0, 7, 1, 1, 0);
        // Test 4: restart pending at addr 5 forward.
        add("to6_tick", K0, 1, 0, 1, 7, 1, 1, 0);
        add("to6_ack", K0, 0, 1, 0, 6, 1, 1, 0);
        add("to5_tick", K0, 1, 0, 1, 6, 1, 1, 0);
        add("to5_ack", K0, 0, 1, 0, 5, 1, 1, 0);
        add("key_f", KF, 0, 0, 0, 5, 1, 0, 0);
        add("p5_tick", K0, 1, 0, 1, 5, 1, 0, 0);
        add("p5_key_r", KR, 0, 0, 1, 5, 1, 0, 0);
        add("p5_wait", K0, 0, 0, 1, 5, 1, 0, 0);
        add("p5_ack", K0, 0, 1, 0, 0, 1, 0, 0);
        // Test 5: key priority, idle ticks, spurious ack, tick with ack.
        add("d_and_e", KD | KE, 0, 0, 0, 0, 0, 0, 0);
        add("idle_tick", K0, 1, 0, 0, 0, 0, 0, 0);
        add("idle_wait", K0, 0, 0, 0, 0, 0, 0, 0);
        add("restart_e", KE, 0, 0, 0, 0, 1, 0, 0);
        add("spurious_ack", K0, 0, 1, 0, 0, 1, 0, 0);
        add("t5_tick", K0, 1, 0, 1, 0, 1, 0, 0);
        add("t5_ack", K0, 0, 1, 0, 1, 1, 0, 0);
        add("r_no_pend", KR, 0, 0, 0, 0, 1, 0, 0);
        add("t5_tick2", K0, 1, 0, 1, 0, 1, 0, 0);
        add("tick_with_ack", K0, 1, 1, 0, 1, 1, 0, 0);
        add("tick_dropped", K0, 0, 0, 0, 1, 1, 0, 0);
        add("f_over_b", KF | KB, 0, 0, 0, 1, 1, 0, 0);
        add("b_alone", KB, 0, 0, 0, 1, 1, 1, 0);
        add("r_over_d", KR | KD, 0, 0, 0, 7, 1, 1, 0);
        add("d_over_ef", KD | KE | KF, 0, 0, 0, 7, 0, 1, 0);
        add("e_over_b", KE | KB, 0, 0, 0, 7, 1, 1, 0);
        // Test 6 prelude: request pending with a latched restart.
        add("t6_tick", K0, 1, 0, 1, 7, 1, 1, 0);
        add("t6_key_r", KR, 0, 0, 1, 7, 1, 1, 0);

        drive(K0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) step_clk();
        chk("reset_dut1", dut1_vec(), pack(0, S1, 0, 0, 0));
        chk("reset_dut2", dut2_vec(), pack(0, S2, 0, 0, 0));
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].k, vecs[i].tk, vecs[i].ak, 1'b0);
            step_clk();
            chk($sformatf("%s[%0d]", vecs[i].nm, i), dut1_vec(),
                pack(vecs[i].xreq, vecs[i].xaddr, vecs[i].xply, vecs[i].xbw, vecs[i].xovr));
        end

        // Asynchronous reset mid-transaction: outputs drop without a clock edge.
        drive(K0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", dut1_vec(), pack(0, 0, 0, 0, 0));
        step_clk();
        rst_n = 1'b1;
        drive(KE, 0, 0, 0);
        step_clk();
        drive(K0, 1, 0, 0);
        step_clk();
        chk("post_reset_req", dut1_vec(), pack(1, 0, 1, 0, 0));
        drive(K0, 0, 1, 0);
        step_clk();
        chk("reset_clears_pending", dut1_vec(), pack(0, 1, 1, 0, 0));

        // Randomized traffic on both instances against the model.
        drive(K0, 0, 0, 0);
        rst_n = 1'b0;
        step_clk();
        rst_n = 1'b1;
        m1 = mreset(S1);
        m2 = mreset(S2);
        for (int c = 0; c < 3000; c++) begin
            bit [4:0] k;
            bit       tk, a1, a2;
            for (int j = 0; j < 5; j++) k[j] = ($urandom_range(15) == 0);
            tk = ($urandom_range(3) == 0);
            a1 = m1.req ? ($urandom_range(2) == 0) : (!tk && $urandom_range(9) == 0);
            a2 = m2.req ? ($urandom_range(2) == 0) : (!tk && $urandom_range(9) == 0);
            drive(k, tk, a1, a2);
            step_clk();
            m1 = mstep(m1, S1, E1, P1, k, tk, a1);
            m2 = mstep(m2, S2, E2, P2, k, tk, a2);
            chk($sformatf("rand_dut1_c%0d", c), dut1_vec(),
                pack(m1.req, m1.addr, m1.ply, m1.bw, m1.ovr));
            chk($sformatf("rand_dut2_c%0d", c), dut2_vec(),
                pack(m2.req, m2.addr, m2.ply, m2.bw, m2.ovr));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kbd_addr_sequencer.md
Name: kbd_addr_sequencer

Overview:
- Parametrised keyboard-driven playback address sequencer for the flash audio path.
- Converts one-cycle key pulses (D stop, E start, B backward, F forward, R restart) into a play/direction mode.
- On each sample tick while playing, issues one flash read request/acknowledge transaction at the current address, then steps the address forward or backward with bounded wrap.
- Sits between the keyboard decoder and the flash read controller.

Parameters:
ADDR_W, 23, address width in bits.
START_ADDR, 0, first playable address (inclusive).
END_ADDR, 23'h7FFFF, last playable address (inclusive); must be >= START_ADDR.
STEP, 1, address increment/decrement per sample; must be >= 1.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
key_d  in  1  stop pulse, one cycle wide.
key_e  in  1  start pulse.
key_b  in  1  select backward pulse.
key_f  in  1  select forward pulse.
key_r  in  1  restart pulse.
sample_tick  in  1  one-cycle sample-rate strobe.
rd_ack  in  1  flash read done, one cycle wide.
rd_req  out  1  read request; held high until rd_ack.
addr  out  ADDR_W  read address; stable while rd_req is high.
playing  out  1  high in FW or BW.
dir_bw  out  1  high when the direction is backward.
tick_overrun  out  1  sticky; set when sample_tick arrives while rd_req is high; cleared by key_r.

Behaviour:
- Reset values (async, rst_n low):
  - mode = IDLE_FW
  - addr = START_ADDR
  - rd_req = 0
  - tick_overrun = 0
- Mode FSM states: IDLE_FW, IDLE_BW, FW, BW. Key priority per cycle: R > D > E > F > B. Only the highest-priority key present in a cycle acts.
  - key_d: FW -> IDLE_FW, BW -> IDLE_BW. Idle states are unchanged.
  - key_e: IDLE_FW -> FW, IDLE_BW -> BW. Playing states are unchanged.
  - key_f: IDLE_BW -> IDLE_FW, BW -> FW. Play/idle status is kept.
  - key_b: IDLE_FW -> IDLE_BW, FW -> BW. Play/idle status is kept.
  - key_r: mode is unchanged. The restart target is START_ADDR if the direction is forward, END_ADDR if backward. tick_overrun clears.
- Fetch handshake:
  - If playing, rd_req = 0 and sample_tick = 1: rd_req rises on the next edge with the current addr (1-cycle latency).
  - rd_req stays high and addr stays frozen until the cycle rd_ack = 1. rd_req is low in the following cycle.
  - rd_ack while rd_req = 0 is ignored.
- Advance: on the rd_ack edge, addr steps by +STEP (FW) or -STEP (BW), using the direction at that edge.
  - If the mode went idle while the request was pending, the transaction still completes and the advance still applies.
  - No new request is issued while idle.
- Bounds, forward: if addr + STEP > END_ADDR, the next addr is START_ADDR. Compute in ADDR_W+1 bits so no overflow occurs.
- Bounds, backward: if addr < START_ADDR + STEP, the next addr is END_ADDR.
- Restart timing:
  - With no request pending, addr loads the restart target on the next edge.
  - With a request pending, the restart is latched. On rd_ack, addr loads the target instead of the advance.
  - A later key_r before the ack overwrites the latched target with one based on the current direction.
- Simultaneous events:
  - sample_tick in the same cycle as rd_ack: no request issues that cycle; the tick is dropped with no overrun flag. The next request issues on the next tick.
  - sample_tick while rd_req is high: sets tick_overrun.
- Reset mid-transaction: rd_req drops immediately (async) and the pending restart clears.

Optional Feature:
KBD_SEQ_LOOP_EN
- Defined: wrap-around as specified above.
- Undefined: no wrap; playback stops at the bound.
  - A forward advance that would pass END_ADDR leaves addr at END_ADDR and the mode goes to IDLE_FW.
  - A backward advance below START_ADDR leaves addr at START_ADDR and the mode goes to IDLE_BW.
  - The transition takes effect on the rd_ack edge.

Test Plan:
1. Params START=0, END=7, STEP=1, loop on. Sequence: reset; key_e; 3 ticks, each acked 2 cycles later. Required: rd_req addr sequence 0,1,2, ending with addr=3 and playing=1.
2. Start from addr=7 in FW; tick; ack. Required: addr=0. Then key_b; tick; ack. Required: addr=7, dir_bw=1.
3. Hold rd_ack low for 10 cycles with 2 ticks during that window. Required: rd_req high and addr constant throughout, tick_overrun=1. Then key_r. Required: tick_overrun=0.
4. key_r at addr=5 in FW while a request is pending. Required: addr stays 5 until the ack, then becomes 0 (not 6).
5. key_d and key_e in the same cycle while in FW. Required: IDLE_FW. Then key_e. Required: FW. A tick while idle produces no rd_req.
6. Loop off, addr=7 in FW; tick; ack. Required: addr=7, mode IDLE_FW, playing=0. Then assert rst_n low while rd_req is high. Required: rd_req=0 immediately and addr=0.
